// File: rtl/vga_sync_out_if.sv
// ----------------------------------------------------------------------------
// vga_sync_out_if
// Purpose : bundles the pixel-address / colour / sync signals exchanged between
//           the VGA timing generator, the upstream colour stage and the pins.
// Signals : COLOUR_IN  [11:0] RGB444 from the colour stage
//           ADDRH      [9:0]  horizontal pixel address (0 outside visible area)
//           ADDRV      [8:0]  vertical pixel address (0 outside visible area)
//           COLOUR_OUT [11:0] RGB444 to the DAC pins
//           HS, VS            horizontal / vertical sync
//           PIX_TICK          one-CLK pixel enable pulse
//           FRAME_END         one-CLK pulse on the tick that wraps the frame
// Modports: master = timing generator side, slave = colour stage / sink side.
// ----------------------------------------------------------------------------
interface vga_sync_out_if;
  logic [11:0] COLOUR_IN;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [11:0] COLOUR_OUT;
  logic        HS;
  logic        VS;
  logic        PIX_TICK;
  logic        FRAME_END;

  modport master (
    input  COLOUR_IN,
    output ADDRH, ADDRV, COLOUR_OUT, HS, VS, PIX_TICK, FRAME_END
  );

  modport slave (
    output COLOUR_IN,
    input  ADDRH, ADDRV, COLOUR_OUT, HS, VS, PIX_TICK, FRAME_END
  );
endinterface

// File: rtl/vga_sync_out.sv
// ----------------------------------------------------------------------------
// vga_sync_out
// Purpose : VGA timing generator plus registered output stage. A clock divider
//           produces a pixel enable (PIX_TICK); horizontal/vertical counters
//           walk the full raster; the pixel address goes to the colour stage
//           and the returned colour is registered together with HS/VS so that
//           all three describe the same pixel (one pixel of latency).
// Ports   : CLK    - system clock, rising edge
//           RESETN - asynchronous active-low reset
//           vif    - vga_sync_out_if.master (COLOUR_IN in; ADDRH, ADDRV,
//                    COLOUR_OUT, HS, VS, PIX_TICK, FRAME_END out)
// ----------------------------------------------------------------------------
module vga_sync_out #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic               CLK,
  input  logic               RESETN,
  vga_sync_out_if.master     vif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_tick;
  logic             r_frame_end;
  logic [9:0]       r_hcnt;
  logic [9:0]       r_vcnt;
  logic [9:0]       r_addrh;
  logic [8:0]       r_addrv;
  logic [11:0]      r_colour;
  logic             r_hs;
  logic             r_vs;

  logic             w_div_wrap;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_video_on;
  logic             w_hs_active;
  logic             w_vs_active;
  logic [9:0]       w_hcnt_next;
  logic [9:0]       w_vcnt_next;

  assign w_div_wrap  = (r_div == DIV_LAST);
  assign w_h_last    = (r_hcnt == H_LAST);
  assign w_v_last    = (r_vcnt == V_LAST);
  assign w_video_on  = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
  assign w_hs_active = (r_hcnt >= H_SYNC_LO) && (r_hcnt <= H_SYNC_HI);
  assign w_vs_active = (r_vcnt >= V_SYNC_LO) && (r_vcnt <= V_SYNC_HI);

  // Next raster position: advance horizontally, wrap into the next line / frame.
  always_comb begin
    w_hcnt_next = r_hcnt;
    w_vcnt_next = r_vcnt;
    if (w_h_last) begin
      w_hcnt_next = 10'd0;
      if (w_v_last) begin
        w_vcnt_next = 10'd0;
      end else begin
        w_vcnt_next = r_vcnt + 10'd1;
      end
    end else begin
      w_hcnt_next = r_hcnt + 10'd1;
      w_vcnt_next = r_vcnt;
    end
  end

  // Clock divider; the pixel tick and frame-end pulse are registered off its wrap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_div       <= '0;
      r_pix_tick  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_pix_tick  <= w_div_wrap;
      // counters are stable across the divider period, so the wrap position
      // seen now is the one the coming tick will act on
      r_frame_end <= w_div_wrap && w_h_last && w_v_last;
    end
  end

  // Raster counters, advanced once per pixel tick.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else if (r_pix_tick) begin
      r_hcnt <= w_hcnt_next;
      r_vcnt <= w_vcnt_next;
    end else begin
      r_hcnt <= r_hcnt;
      r_vcnt <= r_vcnt;
    end
  end

  // Pixel address to the colour stage, one CLK behind the counters.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_addrh <= 10'd0;
      r_addrv <= 9'd0;
    end else if (w_video_on) begin
      r_addrh <= r_hcnt;
      r_addrv <= r_vcnt[8:0];
    end else begin
      r_addrh <= 10'd0;
      r_addrv <= 9'd0;
    end
  end

  // Output stage: sample colour and sync for the current pixel before the counters move.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_colour <= 12'h000;
      r_hs     <= ~SYNC_POL;
      r_vs     <= ~SYNC_POL;
    end else if (r_pix_tick) begin
      r_colour <= w_video_on ? vif.COLOUR_IN : 12'h000;
      r_hs     <= w_hs_active ? SYNC_POL : ~SYNC_POL;
      r_vs     <= w_vs_active ? SYNC_POL : ~SYNC_POL;
    end else begin
      r_colour <= r_colour;
      r_hs     <= r_hs;
      r_vs     <= r_vs;
    end
  end

  assign vif.ADDRH      = r_addrh;
  assign vif.ADDRV      = r_addrv;
  assign vif.COLOUR_OUT = r_colour;
  assign vif.HS         = r_hs;
  assign vif.VS         = r_vs;
  assign vif.PIX_TICK   = r_pix_tick;
  assign vif.FRAME_END  = r_frame_end;

endmodule

// File: tb/tb_vga_sync_out.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_out
// Two instances: u_def with the 640x480 timing (one line and a bit, constant
// white input) and u_sml with a shrunken raster (25x15 pixels) so that whole
// frames, the mid-frame reset and frame-end spacing fit in a short run. The
// small instance's colour stage is a 2-CLK pipeline returning
// {ADDRV[3:0],ADDRH[7:0]}. Expected values come from the CLK count since reset
// release, using the raster arithmetic directly.
// ----------------------------------------------------------------------------
module tb_vga_sync_out;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_sync_out_if bus_d ();
  vga_sync_out_if bus_s ();

  vga_sync_out u_def (
    .CLK    (clk),
    .RESETN (rstn),
    .vif    (bus_d)
  );

  vga_sync_out #(
    .CLK_DIV(4), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_sml (
    .CLK    (clk),
    .RESETN (rstn),
    .vif    (bus_s)
  );

  // colour stage models
  logic [11:0] d1 = 12'h000;
  logic [11:0] d2 = 12'h000;
  always @(posedge clk) begin
    d1 <= {bus_s.ADDRV[3:0], bus_s.ADDRH[7:0]};
    d2 <= d1;
  end
  assign bus_s.COLOUR_IN = d2;
  assign bus_d.COLOUR_IN = 12'hFFF;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".d.TICK"}, 0, 32'(bus_d.PIX_TICK), 32'd0);
    chk({tag, ".d.FE"},   0, 32'(bus_d.FRAME_END), 32'd0);
    chk({tag, ".d.AH"},   0, 32'(bus_d.ADDRH), 32'd0);
    chk({tag, ".d.AV"},   0, 32'(bus_d.ADDRV), 32'd0);
    chk({tag, ".d.COL"},  0, 32'(bus_d.COLOUR_OUT), 32'd0);
    chk({tag, ".d.HS"},   0, 32'(bus_d.HS), 32'd1);
    chk({tag, ".d.VS"},   0, 32'(bus_d.VS), 32'd1);
    chk({tag, ".s.TICK"}, 0, 32'(bus_s.PIX_TICK), 32'd0);
    chk({tag, ".s.FE"},   0, 32'(bus_s.FRAME_END), 32'd0);
    chk({tag, ".s.AH"},   0, 32'(bus_s.ADDRH), 32'd0);
    chk({tag, ".s.AV"},   0, 32'(bus_s.ADDRV), 32'd0);
    chk({tag, ".s.COL"},  0, 32'(bus_s.COLOUR_OUT), 32'd0);
    chk({tag, ".s.HS"},   0, 32'(bus_s.HS), 32'd1);
    chk({tag, ".s.VS"},   0, 32'(bus_s.VS), 32'd1);
  endtask

  // c = CLK negedges since reset release (release happens on a negedge, c=0)
  task automatic check_cycle(input string nm, input int c,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input bit model,
                             input logic tick, input logic fe, input logic [9:0] ah,
                             input logic [8:0] av, input logic [11:0] col,
                             input logic hs, input logic vs);
    int ht, vt, fr, pa, h, v, n, p;
    logic e_tick, e_fe, e_hs, e_vs;
    logic [9:0]  e_ah;
    logic [8:0]  e_av;
    logic [11:0] e_col;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    fr = ht * vt;
    e_tick = (c > 0) && (c % 4 == 0);
    e_fe   = e_tick && (((c / 4 - 1) % fr) == fr - 1);
    pa = (c >= 2) ? (c - 2) / 4 : 0;
    h  = pa % ht;
    v  = (pa / ht) % vt;
    e_ah = (h < hv && v < vv) ? 10'(h) : 10'd0;
    e_av = (h < hv && v < vv) ?  9'(v) :  9'd0;
    n = (c - 1) / 4;
    if (n == 0) begin
      e_col = 12'h000;
      e_hs  = 1'b1;
      e_vs  = 1'b1;
    end else begin
      p = n - 1;
      h = p % ht;
      v = (p / ht) % vt;
      if (h < hv && v < vv) e_col = model ? {v[3:0], h[7:0]} : 12'hFFF;
      else                  e_col = 12'h000;
      e_hs = (h >= hv + hf && h < hv + hf + hsw) ? 1'b0 : 1'b1;
      e_vs = (v >= vv + vf && v < vv + vf + vsw) ? 1'b0 : 1'b1;
    end
    chk({nm, ".TICK"}, c, 32'(tick), 32'(e_tick));
    chk({nm, ".FE"},   c, 32'(fe),   32'(e_fe));
    chk({nm, ".AH"},   c, 32'(ah),   32'(e_ah));
    chk({nm, ".AV"},   c, 32'(av),   32'(e_av));
    chk({nm, ".COL"},  c, 32'(col),  32'(e_col));
    chk({nm, ".HS"},   c, 32'(hs),   32'(e_hs));
    chk({nm, ".VS"},   c, 32'(vs),   32'(e_vs));
  endtask

  task automatic check_both(input int c);
    check_cycle("def", c, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                bus_d.PIX_TICK, bus_d.FRAME_END, bus_d.ADDRH, bus_d.ADDRV,
                bus_d.COLOUR_OUT, bus_d.HS, bus_d.VS);
    check_cycle("sml", c, 16, 2, 4, 3, 8, 2, 2, 3, 1'b1,
                bus_s.PIX_TICK, bus_s.FRAME_END, bus_s.ADDRH, bus_s.ADDRV,
                bus_s.COLOUR_OUT, bus_s.HS, bus_s.VS);
  endtask

  initial begin
    int hs_low_d;
    int vs_low_s;
    int fe_s;
    int fe_d;
    int first_fe;
    hs_low_d = 0;
    vs_low_s = 0;
    fe_s     = 0;
    fe_d     = 0;
    first_fe = -1;

    // reset held
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");

    // release and run two small frames / one default line, then on to the
    // point where the small raster shows pixel (19,10): HS and VS both active
    rstn = 1'b1;
    for (int c = 1; c <= 4082; c++) begin
      @(negedge clk);
      check_both(c);
      if (c <= 3400) begin
        if (bus_d.HS === 1'b0)        hs_low_d++;
        if (bus_s.VS === 1'b0)        vs_low_s++;
        if (bus_s.FRAME_END === 1'b1) fe_s++;
        if (bus_d.FRAME_END === 1'b1) fe_d++;
      end
    end
    chk("hs_low_cycles_def", 3400, 32'(hs_low_d), 32'd384);
    chk("vs_low_cycles_sml", 3400, 32'(vs_low_s), 32'd400);
    chk("frame_end_cnt_sml", 3400, 32'(fe_s), 32'd2);
    chk("frame_end_cnt_def", 3400, 32'(fe_d), 32'd0);
    chk("sync_active_sml_hs", 4082, 32'(bus_s.HS), 32'd0);
    chk("sync_active_sml_vs", 4082, 32'(bus_s.VS), 32'd0);

    // asynchronous mid-frame reset, between clock edges
    #2;
    rstn = 1'b0;
    #1;
    chk_reset("async");
    repeat (2) @(negedge clk);
    chk_reset("hold");

    // restart: timing begins again at (0,0); next frame end after a full frame
    rstn = 1'b1;
    fe_s = 0;
    for (int c = 1; c <= 1600; c++) begin
      @(negedge clk);
      check_both(c);
      if (bus_s.FRAME_END === 1'b1) begin
        fe_s++;
        if (first_fe < 0) first_fe = c;
      end
    end
    chk("frame_end_cnt_after_rst", 1600, 32'(fe_s), 32'd1);
    chk("frame_end_cyc_after_rst", 1600, 32'(first_fe), 32'd1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
